// File: rtl/comando_botoes.sv
// Pushbutton front-end: sync + debounce two active-low buttons into sticky up/down requests.
// Define COMANDO_AUTO_REPEAT_EN to emit repeated press events while a button stays held.
module comando_botoes #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 50000000
) (
  input  logic       clk50mhz,
  input  logic       reset,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       tick,
  output logic       up,
  output logic       down,
  output logic [1:0] press_evt
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCheckPress,
    StHeld,
    StCheckRelease
  } deb_state_e;

  // Bit 1 is the up button, bit 0 the down button throughout.
  logic [1:0] raw;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] evt;

  assign raw = {btn_up_n, btn_down_n};

  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_btn
    deb_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pressed;
    logic            deb_evt;

    assign pressed = ~sync2_q[b];

    always_ff @(posedge clk50mhz) begin
      if (reset) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      deb_evt = 1'b0;
      case (state_q)
        StIdle: begin
          if (pressed) begin
            state_d = StCheckPress;
            cnt_d   = '0;
          end
        end
        StCheckPress: begin
          if (!pressed) begin
            state_d = StIdle;
          end else if (cnt_q == CntLast) begin
            state_d = StHeld;
            deb_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StHeld: begin
          if (!pressed) begin
            state_d = StCheckRelease;
            cnt_d   = '0;
          end
        end
        StCheckRelease: begin
          if (pressed) begin
            state_d = StHeld;
          end else if (cnt_q == CntLast) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

`ifdef COMANDO_AUTO_REPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);

    logic [RepW-1:0] rep_q, rep_d;
    logic            rep_evt;

    // Runs only in HELD, so a bouncing release pauses rather than restarts the period.
    always_comb begin
      rep_d   = rep_q;
      rep_evt = 1'b0;
      if (state_q == StHeld) begin
        if (rep_q == RepLast) begin
          rep_evt = 1'b1;
          rep_d   = '0;
        end else begin
          rep_d = rep_q + RepW'(1);
        end
      end
      if (deb_evt) begin
        rep_d = '0;
      end
    end

    always_ff @(posedge clk50mhz) begin
      if (reset) begin
        rep_q <= '0;
      end else begin
        rep_q <= rep_d;
      end
    end

    assign evt[b] = deb_evt | rep_evt;
`else
    assign evt[b] = deb_evt;
`endif
  end

  logic       up_q, up_d;
  logic       down_q, down_d;
  logic [1:0] press_evt_q;

  // A press landing in the tick cycle wins, so it is presented at the next tick.
  always_comb begin
    up_d   = up_q;
    down_d = down_q;
    if (evt[1]) begin
      up_d = 1'b1;
    end else if (tick) begin
      up_d = 1'b0;
    end
    if (evt[0]) begin
      down_d = 1'b1;
    end else if (tick) begin
      down_d = 1'b0;
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      press_evt_q <= 2'b00;
    end else begin
      up_q        <= up_d;
      down_q      <= down_d;
      press_evt_q <= evt;
    end
  end

  assign up        = up_q;
  assign down      = down_q;
  assign press_evt = press_evt_q;

endmodule

// File: tb/tb_comando_botoes.sv
// Self-checking bench for comando_botoes: run-length behavioural model plus directed scenarios.
module tb_comando_botoes;

  localparam int unsigned D = 4;
  localparam int unsigned R = 10;

  logic       clk50mhz = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up_n = 1'b1;
  logic       btn_down_n = 1'b1;
  logic       tick = 1'b0;
  logic       up;
  logic       down;
  logic [1:0] press_evt;

  comando_botoes #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk50mhz  (clk50mhz),
    .reset     (reset),
    .btn_up_n  (btn_up_n),
    .btn_down_n(btn_down_n),
    .tick      (tick),
    .up        (up),
    .down      (down),
    .press_evt (press_evt)
  );

  always #5 clk50mhz = ~clk50mhz;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pins seen two edges late; a level change is accepted after D+1 consecutive
  // opposite samples. Requests are sticky until a tick without a coinciding press.
  logic [1:0] m_s1, m_s2;
  bit         m_held[2];
  int         m_run[2];
  int         m_rep[2];
  logic       m_up = 1'b0;
  logic       m_down = 1'b0;
  logic [1:0] m_evt = 2'b00;
  bit         m_valid = 1'b0;

  task automatic model_step();
    logic [1:0] ev;
    logic       smp;
    ev = 2'b00;
    if (reset) begin
      m_s1 = 2'b11;
      m_s2 = 2'b11;
      for (int b = 0; b < 2; b++) begin
        m_held[b] = 1'b0;
        m_run[b]  = 0;
        m_rep[b]  = 0;
      end
      m_up    = 1'b0;
      m_down  = 1'b0;
      m_evt   = 2'b00;
      m_valid = 1'b1;
      return;
    end
    for (int b = 0; b < 2; b++) begin
      smp = m_s2[b];
      if (!m_held[b]) begin
        m_run[b] = smp ? 0 : m_run[b] + 1;
        if (m_run[b] == D + 1) begin
          ev[b]     = 1'b1;
          m_held[b] = 1'b1;
          m_run[b]  = 0;
          m_rep[b]  = 0;
        end
      end else begin
`ifdef COMANDO_AUTO_REPEAT_EN
        if (m_run[b] == 0) begin
          if (m_rep[b] == R - 1) begin
            ev[b]    = 1'b1;
            m_rep[b] = 0;
          end else begin
            m_rep[b] = m_rep[b] + 1;
          end
        end
`endif
        m_run[b] = smp ? m_run[b] + 1 : 0;
        if (m_run[b] == D + 1) begin
          m_held[b] = 1'b0;
          m_run[b]  = 0;
        end
      end
    end
    m_evt  = ev;
    m_up   = ev[1] ? 1'b1 : (tick ? 1'b0 : m_up);
    m_down = ev[0] ? 1'b1 : (tick ? 1'b0 : m_down);
    m_s2   = m_s1;
    m_s1   = {btn_up_n, btn_down_n};
  endtask

  initial forever begin
    @(posedge clk50mhz);
    model_step();
  end

  initial forever begin
    @(negedge clk50mhz);
    if (m_valid) begin
      check("model_up", {31'd0, up}, {31'd0, m_up});
      check("model_down", {31'd0, down}, {31'd0, m_down});
      check("model_evt", {30'd0, press_evt}, {30'd0, m_evt});
    end
  end

  // Advances n edges from the drive slot (posedge+2), noting press_evt pulses under mask.
  task automatic run_watch(input int n, input logic [1:0] mask, output int first,
                           output int cnt, output logic [1:0] val);
    first = -1;
    cnt   = 0;
    val   = 2'b00;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk50mhz);
      #1;
      if ((press_evt & mask) != 2'b00) begin
        cnt++;
        if (first < 0) begin
          first = i;
          val   = press_evt;
        end
      end
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  int         first;
  int         cnt;
  int         acc;
  logic [1:0] val;
  int         rep_at[$];

  initial begin
    repeat (3) @(posedge clk50mhz);
    #2;
    check("reset_up", {31'd0, up}, 32'd0);
    check("reset_down", {31'd0, down}, 32'd0);
    check("reset_evt", {30'd0, press_evt}, 32'd0);
    reset = 1'b0;
    run_watch(2, 2'b11, first, cnt, val);

    // Clean press on up.
    btn_up_n = 1'b0;
    run_watch(20, 2'b11, first, cnt, val);
    check("clean_evt_cycle", first, 32'd7);
    check("clean_evt_val", {30'd0, val}, 32'd2);
`ifdef COMANDO_AUTO_REPEAT_EN
    check("clean_evt_cnt", cnt, 32'd2);
`else
    check("clean_evt_cnt", cnt, 32'd1);
`endif
    check("clean_up", {31'd0, up}, 32'd1);
    check("clean_down", {31'd0, down}, 32'd0);
    btn_up_n = 1'b1;
    run_watch(10, 2'b11, first, cnt, val);
    check("release_no_evt", cnt, 32'd0);
    check("up_sticky", {31'd0, up}, 32'd1);

    // Bouncing down button, low runs of 2 samples only.
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      btn_down_n = (k % 2 == 0) ? 1'b0 : 1'b1;
      run_watch(2, 2'b01, first, cnt, val);
      acc += cnt;
    end
    btn_down_n = 1'b1;
    run_watch(10, 2'b01, first, cnt, val);
    acc += cnt;
    check("bounce_no_evt", acc, 32'd0);
    check("bounce_down", {31'd0, down}, 32'd0);

    // Second press with tick sampled on the accepting edge: request must survive.
    btn_up_n = 1'b0;
    run_watch(6, 2'b11, first, cnt, val);
    tick = 1'b1;
    run_watch(1, 2'b11, first, cnt, val);
    tick = 1'b0;
    check("collision_evt", {30'd0, press_evt}, 32'd2);
    check("collision_up", {31'd0, up}, 32'd1);
    tick = 1'b1;
    run_watch(1, 2'b11, first, cnt, val);
    tick = 1'b0;
    check("tick_clear_up", {31'd0, up}, 32'd0);
    btn_up_n = 1'b1;
    run_watch(10, 2'b11, first, cnt, val);

    // Both buttons together.
    btn_up_n   = 1'b0;
    btn_down_n = 1'b0;
    run_watch(10, 2'b11, first, cnt, val);
    check("both_evt_cycle", first, 32'd7);
    check("both_evt_val", {30'd0, val}, 32'd3);
    check("both_up", {31'd0, up}, 32'd1);
    check("both_down", {31'd0, down}, 32'd1);
    tick = 1'b1;
    run_watch(1, 2'b11, first, cnt, val);
    tick = 1'b0;
    check("both_clear", {30'd0, up, down}, 32'd0);
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    run_watch(10, 2'b11, first, cnt, val);

    // Reset in the middle of a press, button kept held.
    btn_up_n = 1'b0;
    run_watch(4, 2'b11, first, cnt, val);
    reset = 1'b1;
    run_watch(1, 2'b11, first, cnt, val);
    check("rst_outputs", {29'd0, up, down, press_evt}, 32'd0);
    reset = 1'b0;
    run_watch(10, 2'b10, first, cnt, val);
    check("rst_repress_cycle", first, 32'd7);
    check("rst_repress_up", {31'd0, up}, 32'd1);
    btn_up_n = 1'b1;
    run_watch(10, 2'b11, first, cnt, val);
    tick = 1'b1;
    run_watch(1, 2'b11, first, cnt, val);
    tick = 1'b0;

    // Long hold with periodic ticks.
    btn_up_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick = (i % 5 == 0) ? 1'b1 : 1'b0;
      @(posedge clk50mhz);
      #1;
      if (press_evt[1]) rep_at.push_back(i);
      #1;
    end
    tick = 1'b0;
`ifdef COMANDO_AUTO_REPEAT_EN
    check("repeat_count", rep_at.size(), 32'd4);
    for (int j = 0; j < rep_at.size() && j < 4; j++) begin
      check("repeat_cycle", rep_at[j], 32'(7 + 10 * j));
    end
`else
    check("repeat_count", rep_at.size(), 32'd1);
    if (rep_at.size() > 0) check("repeat_cycle", rep_at[0], 32'd7);
`endif
    btn_up_n = 1'b1;
    run_watch(10, 2'b11, first, cnt, val);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
